// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter
//
// Shares a single aes_encrypt_core between two requesters. One job is in
// flight at a time: a requester is granted in IDLE, the core is started for
// one cycle, the arbiter waits in BUSY for core_finish (with a timeout), and
// the result is held in RESP until the response handshake completes.
//
// Ports
//   clk, nrst                    clock and asynchronous active-low reset
//   reqN_valid / reqN_ready      job handshake for requester N (N = 0, 1)
//   reqN_plain_text, reqN_key    128-bit job operands for requester N
//   rsp_valid / rsp_ready        response handshake
//   rsp_id                       requester that owns the response
//   rsp_err                      response was produced by a timeout
//   rsp_data                     cipher text (zero on timeout)
//   core_start                   one-cycle start pulse to the core
//   core_finish                  core reports completion
//   core_bus_free                core may accept a new job
//   core_plain_text, core_key    registered operands driven to the core
//   core_cipher_text             result from the core
module aes_core_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [127:0] req0_plain_text,
  input  logic [127:0] req1_plain_text,
  input  logic [127:0] req0_key,
  input  logic [127:0] req1_key,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic         rsp_err,
  output logic [127:0] rsp_data,
  output logic         core_start,
  input  logic         core_finish,
  input  logic         core_bus_free,
  output logic [127:0] core_plain_text,
  output logic [127:0] core_key,
  input  logic [127:0] core_cipher_text
);

  // The BUSY counter only needs to reach TIMEOUT-1: it is 0 in the first
  // BUSY cycle, so the TIMEOUT-th BUSY cycle is the one where it equals
  // TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY,
    RESP
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] busy_cnt;
  logic             prefer1;
  logic             grant_valid;
  logic             grant_id;
  logic             finish_ok;
  logic             timed_out;

  // Round-robin grant. Gated by nrst so no ready can leak out while the
  // block is held in reset with requests pending.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (nrst && (state == IDLE) && core_bus_free) begin
      if (req0_valid && req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = prefer1;
      end else if (req0_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end else if (req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end
  end

  assign req0_ready = grant_valid && !grant_id;
  assign req1_ready = grant_valid && grant_id;

  // A finish level seen in the very first BUSY cycle may be left over from
  // the previous job, so it is not trusted. On the last BUSY cycle a real
  // finish takes priority over the timeout.
  assign finish_ok = (state == BUSY) && (busy_cnt != '0) && core_finish;
  assign timed_out = (state == BUSY) && (busy_cnt == CNT_LAST) && !finish_ok;

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the core start pulse.
  always_comb begin
    state_next = state;
    core_start = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          state_next = START;
        end
      end
      START: begin
        core_start = 1'b1;
        state_next = BUSY;
      end
      BUSY: begin
        if (finish_ok || timed_out) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Job operands, response registers, timeout counter and round-robin
  // pointer. The pointer moves only when a response is handed over, so an
  // aborted job leaves the preference untouched until reset clears it.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      core_plain_text <= '0;
      core_key        <= '0;
      rsp_valid       <= 1'b0;
      rsp_err         <= 1'b0;
      rsp_id          <= 1'b0;
      rsp_data        <= '0;
      busy_cnt        <= '0;
      prefer1         <= 1'b0;
    end else begin
      if (grant_valid) begin
        core_plain_text <= grant_id ? req1_plain_text : req0_plain_text;
        core_key        <= grant_id ? req1_key : req0_key;
        rsp_id          <= grant_id;
      end

      if ((state == BUSY) && (state_next == BUSY)) begin
        busy_cnt <= busy_cnt + CNT_W'(1);
      end else begin
        busy_cnt <= '0;
      end

      if (finish_ok) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b0;
        rsp_data  <= core_cipher_text;
      end else if (timed_out) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
        rsp_data  <= '0;
      end

      if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
        prefer1   <= ~rsp_id;
      end
    end
  end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// tb_aes_core_arbiter
//
// Drives jobs from two requesters into aes_core_arbiter, emulates the AES
// core with a configurable finish delay, and checks every response against
// a queue of expected responses built from a round-robin model of the
// arbitration rules.
module tb_aes_core_arbiter;

  localparam int TIMEOUT = 8;
  localparam int NEVER   = 1000;

  localparam logic [127:0] KAT_PT  = 128'h3243f6a8_885a308d_313198a2_e0370734;
  localparam logic [127:0] KAT_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] KAT_CT  = 128'h3925841d_02dc09fb_dc118597_196a0b32;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         req0_valid = 1'b0;
  logic         req1_valid = 1'b0;
  logic         req0_ready;
  logic         req1_ready;
  logic [127:0] req0_plain_text = '0;
  logic [127:0] req1_plain_text = '0;
  logic [127:0] req0_key = '0;
  logic [127:0] req1_key = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic         rsp_id;
  logic         rsp_err;
  logic [127:0] rsp_data;
  logic         core_start;
  logic         core_finish = 1'b0;
  logic         core_bus_free = 1'b0;
  logic [127:0] core_plain_text;
  logic [127:0] core_key;
  logic [127:0] core_cipher_text = '0;

  always #5 clk = ~clk;

  aes_core_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk              (clk),
    .nrst             (nrst),
    .req0_valid       (req0_valid),
    .req1_valid       (req1_valid),
    .req0_ready       (req0_ready),
    .req1_ready       (req1_ready),
    .req0_plain_text  (req0_plain_text),
    .req1_plain_text  (req1_plain_text),
    .req0_key         (req0_key),
    .req1_key         (req1_key),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_id           (rsp_id),
    .rsp_err          (rsp_err),
    .rsp_data         (rsp_data),
    .core_start       (core_start),
    .core_finish      (core_finish),
    .core_bus_free    (core_bus_free),
    .core_plain_text  (core_plain_text),
    .core_key         (core_key),
    .core_cipher_text (core_cipher_text)
  );

  typedef struct {
    logic         id;
    logic         err;
    logic [127:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   delay_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: one pending job slot per requester and the
  // requester preferred when both are waiting.
  logic         pend_v[2];
  logic [127:0] pend_p[2];
  logic [127:0] pend_k[2];
  logic         ptr;

  // Stand-in for the AES core: the known-answer vector maps to its real
  // cipher text, anything else to an arbitrary but operand-dependent value.
  function automatic logic [127:0] core_fn(input logic [127:0] p, input logic [127:0] k);
    if ((p == KAT_PT) && (k == KAT_KEY)) begin
      return KAT_CT;
    end
    return {p[63:0] ^ k[127:64], p[127:64] + k[63:0]};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check_output(input string name, input logic [131:0] act,
                              input logic [131:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_ctl"},
                 {126'd0, core_start, rsp_valid, rsp_err, rsp_id, req0_ready, req1_ready},
                 132'd0);
    check_output({tag, "_data"}, {4'd0, rsp_data | core_plain_text | core_key}, 132'd0);
  endtask

  task automatic add_job(input int id, input logic [127:0] p, input logic [127:0] k);
    pend_v[id] = 1'b1;
    pend_p[id] = p;
    pend_k[id] = k;
  endtask

  // Runs one job to completion. delay: cycles from the core_start cycle to
  // the finish pulse (0 = random, NEVER = no finish). stall: response cycles
  // held with rsp_ready low. bus_low: cycles with core_bus_free low before
  // the grant may happen (0 = random bus availability).
  // Entered and left just after a rising edge.
  task automatic apply_stimulus(input int delay, input int stall, input int bus_low);
    int   win;
    int   d;
    int   r;
    int   g;
    int   gc;
    int   n;
    bit   got;
    bit   seen;
    exp_t e;

    win = (pend_v[0] && pend_v[1]) ? (ptr ? 1 : 0) : (pend_v[1] ? 1 : 0);
    if (delay > 0) begin
      d = delay;
    end else begin
      r = $urandom_range(0, 7);
      d = (r == 0) ? 1 : (r == 1) ? TIMEOUT : (r == 2) ? TIMEOUT + 1
                                                       : $urandom_range(2, TIMEOUT);
    end
    e.id   = (win == 1);
    e.err  = (d < 2) || (d > TIMEOUT);
    e.data = e.err ? 128'd0 : core_fn(pend_p[win], pend_k[win]);
    exp_q.push_back(e);
    delay_q.push_back(d);
    ptr = (win == 0);

    req0_valid      = pend_v[0];
    req0_plain_text = pend_p[0];
    req0_key        = pend_k[0];
    req1_valid      = pend_v[1];
    req1_plain_text = pend_p[1];
    req1_key        = pend_k[1];

    got = 1'b0;
    g   = 0;
    gc  = -1;
    for (int c = 0; c < 200; c++) begin
      if (c < bus_low) core_bus_free = 1'b0;
      else if (bus_low > 0) core_bus_free = 1'b1;
      else core_bus_free = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        got = 1'b1;
        g   = req1_ready ? 1 : 0;
        gc  = c;
      end
      @(posedge clk);
      #1;
      if (got) break;
    end
    if (!got) begin
      check_output("grant_timeout", 132'd0, 132'd1);
      return;
    end
    check_output("grant_id", 132'(g), 132'(win));
    if (bus_low > 0) check_output("grant_when_bus_free", 132'(gc), 132'(bus_low));

    pend_v[g] = 1'b0;
    if (g == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
    core_bus_free = 1'b1;

    @(negedge clk);
    check_output("start_after_accept", {131'd0, core_start}, 132'd1);
    check_output("ready_one_cycle", {130'd0, req0_ready, req1_ready}, 132'd0);
    @(posedge clk);
    #1;

    got  = 1'b0;
    seen = 1'b0;
    n    = 0;
    for (int c = 0; c < 4 * TIMEOUT + stall + 20; c++) begin
      if (seen) rsp_ready = (n >= stall);
      else rsp_ready = (stall == 0) && ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        if (rsp_ready) got = 1'b1;
        else n++;
      end
      @(posedge clk);
      #1;
      if (got) break;
    end
    rsp_ready = 1'b0;
    if (!got) check_output("response_timeout", 132'd0, 132'd1);
  endtask

  // Aborts a job in BUSY with a reset pulse and checks that the late finish
  // is ignored. Requests pending across the reset must not see a ready.
  task automatic reset_abort();
    bit got;
    bit late;

    add_job(1, rand128(), rand128());
    delay_q.push_back(6);
    req1_valid      = 1'b1;
    req1_plain_text = pend_p[1];
    req1_key        = pend_k[1];
    core_bus_free   = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req1_ready) got = 1'b1;
      @(posedge clk);
      #1;
      if (got) break;
    end
    check_output("abort_grant", {131'd0, got}, 132'd1);
    req1_valid = 1'b0;
    pend_v[1]  = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    add_job(0, rand128(), rand128());
    add_job(1, rand128(), rand128());
    req0_valid      = 1'b1;
    req0_plain_text = pend_p[0];
    req0_key        = pend_k[0];
    req1_valid      = 1'b1;
    req1_plain_text = pend_p[1];
    req1_key        = pend_k[1];
    nrst = 1'b0;
    #1;
    check_reset_outputs("abort_reset");
    ptr = 1'b0;
    @(posedge clk);
    #1;
    nrst          = 1'b1;
    core_bus_free = 1'b0;
    rsp_ready     = 1'b1;
    late = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rsp_valid) late = 1'b1;
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b0;
    check_output("late_finish_ignored", {131'd0, late}, 132'd0);
  endtask

  // Core emulation: on each start pulse, take the next scheduled delay and
  // raise core_finish for one cycle that many cycles later.
  initial begin
    int           d;
    logic [127:0] p;
    logic [127:0] k;
    forever begin
      @(negedge clk);
      if (nrst && core_start) begin
        if (delay_q.size() == 0) begin
          check_output("unexpected_core_start", 132'd1, 132'd0);
          d = NEVER;
        end else begin
          d = delay_q.pop_front();
        end
        p = core_plain_text;
        k = core_key;
        if (d < NEVER) begin
          repeat (d) @(negedge clk);
          core_cipher_text = core_fn(p, k);
          core_finish      = 1'b1;
          @(negedge clk);
          core_finish      = 1'b0;
          core_cipher_text = rand128();
        end
      end
    end
  end

  // Response monitor: pops the expected queue on every handshake, checks
  // that a stalled response holds steady and that grants stay legal.
  initial begin
    bit           hold;
    logic [129:0] held;
    exp_t         e;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        hold = 1'b0;
      end else begin
        if (req0_ready || req1_ready) begin
          check_output("ready_exclusive", {131'd0, req0_ready & req1_ready}, 132'd0);
          check_output("ready_needs_bus_free", {131'd0, core_bus_free}, 132'd1);
          check_output("ready_during_response", {131'd0, rsp_valid}, 132'd0);
        end
        if (hold) begin
          check_output("rsp_hold", {1'b0, rsp_valid, rsp_id, rsp_err, rsp_data},
                       {2'b01, held});
        end
        hold = rsp_valid && !rsp_ready;
        held = {rsp_id, rsp_err, rsp_data};
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            check_output("unexpected_response", 132'd1, 132'd0);
          end else begin
            e = exp_q.pop_front();
            check_output("rsp_id", {131'd0, rsp_id}, {131'd0, e.id});
            check_output("rsp_err", {131'd0, rsp_err}, {131'd0, e.err});
            check_output("rsp_data", {4'd0, rsp_data}, {4'd0, e.data});
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    pend_v[0] = 1'b0;
    pend_v[1] = 1'b0;
    pend_p[0] = '0;
    pend_p[1] = '0;
    pend_k[0] = '0;
    pend_k[1] = '0;
    ptr       = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    nrst = 1'b1;
    @(posedge clk);
    #1;

    // Both requesters kept busy from reset: grants alternate 0,1,0,1.
    $display("[TB] round-robin from reset");
    add_job(0, rand128(), rand128());
    add_job(1, rand128(), rand128());
    apply_stimulus(3, 0, 0);
    add_job(0, rand128(), rand128());
    apply_stimulus(4, 0, 0);
    add_job(1, rand128(), rand128());
    apply_stimulus(5, 0, 0);
    apply_stimulus(3, 0, 0);

    $display("[TB] known-answer job");
    add_job(0, KAT_PT, KAT_KEY);
    apply_stimulus(4, 0, 0);

    $display("[TB] response back-pressure");
    add_job(0, rand128(), rand128());
    add_job(1, rand128(), rand128());
    apply_stimulus(3, 10, 0);
    apply_stimulus(3, 0, 0);

    $display("[TB] timeout then normal job");
    add_job(0, rand128(), rand128());
    apply_stimulus(NEVER, 0, 0);
    add_job(1, rand128(), rand128());
    apply_stimulus(TIMEOUT, 0, 0);

    $display("[TB] grant waits for core_bus_free");
    add_job(1, rand128(), rand128());
    apply_stimulus(3, 0, 5);

    $display("[TB] withdrawn request is dropped");
    core_bus_free   = 1'b0;
    req1_valid      = 1'b1;
    req1_plain_text = rand128();
    repeat (3) @(posedge clk);
    #1;
    req1_valid = 1'b0;
    add_job(0, rand128(), rand128());
    apply_stimulus(2, 0, 0);

    $display("[TB] reset during BUSY");
    reset_abort();
    apply_stimulus(3, 0, 0);
    apply_stimulus(3, 0, 0);

    $display("[TB] randomized jobs");
    for (int i = 0; i < 40; i++) begin
      for (int id = 0; id < 2; id++) begin
        if (!pend_v[id] && ($urandom_range(0, 1) == 1)) add_job(id, rand128(), rand128());
      end
      if (!pend_v[0] && !pend_v[1]) add_job($urandom_range(0, 1), rand128(), rand128());
      apply_stimulus(0, $urandom_range(0, 3), 0);
    end

    repeat (5) @(posedge clk);
    #1;
    check_output("responses_outstanding", 132'(exp_q.size()), 132'd0);
    check_output("core_jobs_outstanding", 132'(delay_q.size()), 132'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
